// File: rtl/multiple_comparator_tree_pkg.sv
// comparator_pkg
//   Shared definitions for the min/max comparator tree:
//   - MODE_MIN / MODE_MAX : transaction mode encoding (io_mode)
//   - stageCtl_t          : per-level control record (mode, valid) that
//                           travels down the pipeline with the data
//   - clog2               : elaboration-time ceil(log2) helper
package comparator_pkg;

   localparam logic MODE_MIN = 1'b0;
   localparam logic MODE_MAX = 1'b1;

   typedef struct packed {
      logic mode;
      logic valid;
   } stageCtl_t;

   function automatic int clog2(input int n);
      for (int r = 0; r < 31; r++) begin
         if ((1 << r) >= n) return r;
      end
      return 31;
   endfunction

endpackage

// File: rtl/multiple_comparator_tree_node.sv
// comparator_node
//   Combinational two-operand min/max select. Operand a is the lower-index
//   operand; ties keep a so the lowest original index wins. An operand whose
//   lane is invalid (padding slot) never wins against a real lane.
//   Ports:
//     mode                  : MODE_MIN / MODE_MAX
//     aValue/aIndex/aLane   : lower-index operand
//     bValue/bIndex/bLane   : higher-index operand
//     yValue/yIndex/yLane   : selected record, yLane = either lane real
module comparator_node
   import comparator_pkg::*;
#(
   parameter int WIDTH = 3,
   parameter int IDX_W = 2
) (
   input  logic             mode,
   input  logic [WIDTH-1:0] aValue,
   input  logic [IDX_W-1:0] aIndex,
   input  logic             aLane,
   input  logic [WIDTH-1:0] bValue,
   input  logic [IDX_W-1:0] bIndex,
   input  logic             bLane,
   output logic [WIDTH-1:0] yValue,
   output logic [IDX_W-1:0] yIndex,
   output logic             yLane
);

   logic bBetter;
   logic takeB;

   // Strict comparisons: equality keeps a.
   assign bBetter = (mode == MODE_MAX) ? (bValue > aValue) : (bValue < aValue);
   // A padding b never wins; a padding a always loses to a real b.
   assign takeB   = bLane && (!aLane || bBetter);

   assign yValue = takeB ? bValue : aValue;
   assign yIndex = takeB ? bIndex : aIndex;
   assign yLane  = aLane | bLane;

endmodule

// File: rtl/multiple_comparator_tree.sv
// multiple_comparator_tree
//   Pipelined min/max reduction over NUM_INPUTS unsigned WIDTH-bit values.
//   Inputs are padded to P = 2**IDX_W leaves; the tree is a heap of P-1
//   registered comparator nodes (node n has children 2n, 2n+1; leaves are
//   P..2P-1). Latency is IDX_W cycles, one transaction per cycle.
//   Ports:
//     clock, reset          : clock, synchronous active-low reset
//     io_start, io_mode     : transaction valid and min(0)/max(1) select
//     io_hold               : freeze every pipeline register and the counter
//     io_inputs             : NUM_INPUTS operands, element k is input k
//     io_result             : reduced value (last stage)
//     io_resultIndex        : lowest input index holding the winning value
//     io_valid              : last-stage valid bit
//     io_count              : results delivered since reset, wraps at 2^16
module multiple_comparator_tree
   import comparator_pkg::*;
#(
   parameter  int WIDTH      = 3,
   parameter  int NUM_INPUTS = 4,
   localparam int IDX_W      = (clog2(NUM_INPUTS) < 1) ? 1 : clog2(NUM_INPUTS)
) (
   input  logic                             clock,
   input  logic                             reset,
   input  logic                             io_start,
   input  logic                             io_mode,
   input  logic                             io_hold,
   input  logic [NUM_INPUTS-1:0][WIDTH-1:0] io_inputs,
   output logic [WIDTH-1:0]                 io_result,
   output logic [IDX_W-1:0]                 io_resultIndex,
   output logic                             io_valid,
   output logic [15:0]                      io_count
);

   localparam int LEVELS = IDX_W;
   localparam int P      = 1 << IDX_W;

   typedef struct packed {
      logic [WIDTH-1:0] value;
      logic [IDX_W-1:0] index;
      logic             laneValid;
   } rec_t;

   rec_t      leaf  [P];
   rec_t      nodeD [1:P-1];
   rec_t      nodeQ [1:P-1];
   // ctlQ[k] is the control register behind tree level k-1.
   stageCtl_t ctlQ  [1:LEVELS];

   // Leaves: real inputs, then padding slots that can never win.
   for (genvar k = 0; k < P; k++) begin : gLeaf
      if (k < NUM_INPUTS) begin : gReal
         assign leaf[k] = '{value: io_inputs[k], index: IDX_W'(k), laneValid: 1'b1};
      end else begin : gPad
         assign leaf[k] = '{value: '0, index: IDX_W'(k), laneValid: 1'b0};
      end
   end

   for (genvar n = 1; n < P; n++) begin : gNode
      localparam int DEPTH = $clog2(n + 1) - 1;
      localparam int LEVEL = LEVELS - 1 - DEPTH;

      rec_t             a;
      rec_t             b;
      logic             mode;
      logic [WIDTH-1:0] yValue;
      logic [IDX_W-1:0] yIndex;
      logic             yLane;

      if (LEVEL == 0) begin : gFromLeaf
         assign a    = leaf[2*n - P];
         assign b    = leaf[2*n + 1 - P];
         assign mode = io_mode;
      end else begin : gFromNode
         // Mode comes from the same stage as the operands, so back-to-back
         // transactions may use different modes.
         assign a    = nodeQ[2*n];
         assign b    = nodeQ[2*n + 1];
         assign mode = ctlQ[LEVEL].mode;
      end

      comparator_node #(.WIDTH(WIDTH), .IDX_W(IDX_W)) uNode (
         .mode   (mode),
         .aValue (a.value),
         .aIndex (a.index),
         .aLane  (a.laneValid),
         .bValue (b.value),
         .bIndex (b.index),
         .bLane  (b.laneValid),
         .yValue (yValue),
         .yIndex (yIndex),
         .yLane  (yLane)
      );

      assign nodeD[n] = '{value: yValue, index: yIndex, laneValid: yLane};
   end

   // Data registers load regardless of valid; only the valid bits qualify them.
   always_ff @(posedge clock) begin
      if (!reset) begin
         for (int n = 1; n < P; n++) nodeQ[n] <= '0;
         for (int l = 1; l <= LEVELS; l++) ctlQ[l] <= '0;
         io_count <= '0;
      end else if (!io_hold) begin
         for (int n = 1; n < P; n++) nodeQ[n] <= nodeD[n];
         ctlQ[1] <= '{mode: io_mode, valid: io_start};
         for (int l = 2; l <= LEVELS; l++) ctlQ[l] <= ctlQ[l-1];
         if (ctlQ[LEVELS].valid) io_count <= io_count + 16'd1;
      end
   end

   assign io_result      = nodeQ[1].value;
   assign io_resultIndex = nodeQ[1].index;
   assign io_valid       = ctlQ[LEVELS].valid;

   // Root lane flag and last-stage mode are carried but not consumed.
   logic unusedBits;
   assign unusedBits = ^{nodeQ[1].laneValid, ctlQ[LEVELS].mode};

endmodule
